axis_pcie_pipe_pkt: RTL and testbench

// - Parametrised N-stage AXI-S pipeline for the PCIe TX/RX TLP paths; successor to the fixed-width per-interface pipeline regs.
// - Generic in channel count, per-channel data/user width and per-stage mode.
// - Adds beat-occupancy and complete-packet counters, plus packet-atomic hold/drain for quiescing the link (FLR, port reset).
// - Sits between PCIe bridge and AFU mux; one instance per direction.

---
 rtl/axis_pcie_pipe_pkt_pkg.sv | 11 +
 rtl/axis_pcie_pipe_pkt_if.sv | 13 +
 rtl/axis_pcie_pipe_pkt_stage.sv | 30 +++
 rtl/axis_pcie_pipe_pkt.sv | 86 ++++++++
 tb/tb_axis_pcie_pipe_pkt.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_pcie_pipe_pkt_pkg.sv
// axis_pcie_pipe_pkt_pkg: stage mode enum and depth/width helpers shared by the AXI-S pipeline
package axis_pcie_pipe_pkt_pkg;
  typedef enum logic [1:0] {SKID, SIMPLE, BYPASS} t_axis_pipe_mode;
  function automatic int axis_pipe_depth(input int mode);
    return mode == 0 ? 2 : mode == 1 ? 1 : 0;
  endfunction
  // bypass holds nothing, but a port still needs at least one bit
  function automatic int axis_pipe_occ_w(input int n, input int mode);
    return n * axis_pipe_depth(mode) < 1 ? 1 : $clog2(n * axis_pipe_depth(mode) + 1);
  endfunction
endpackage

// File: rtl/axis_pcie_pipe_pkt_if.sv
// axis_pcie_pipe_pkt_if: AXI-Stream beat bundle with master/slave views
interface axis_pcie_pipe_pkt_if #(
  parameter int DW = 256,
  parameter int UW = 10
);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  modport master(output tvalid, tdata, tlast, tuser, input tready);
  modport slave(input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pcie_pipe_pkt_stage.sv
// axis_pcie_pipe_pkt_stage: one pipeline stage, skid (registered ready) or simple (combinational ready)
module axis_pcie_pipe_pkt_stage #(
  parameter int W = 8,
  parameter bit USE_SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic main_v, skid_v, load;
  logic [W-1:0] main_d, skid_d;
  assign out_valid = main_v;
  assign out_data = main_d;
  assign load = ~main_v | out_ready;
  assign in_ready = USE_SKID ? ~skid_v : load;
  // on load the skid entry drains first; a new beat only enters when the skid was empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {main_v, skid_v} <= 2'b00;
    else if (load) {main_v, skid_v} <= {skid_v | in_valid, 1'b0};
    else if (USE_SKID && in_valid && !skid_v) skid_v <= 1'b1;
  always_ff @(posedge clk) begin
    if (load) main_d <= skid_v ? skid_d : in_data;
    if (!load && !skid_v) skid_d <= in_data;
  end
endmodule

// File: rtl/axis_pcie_pipe_pkt.sv
// axis_pcie_pipe_pkt: N-stage AXI-S pipeline with beat/packet counters and packet-atomic hold/drain
module axis_pcie_pipe_pkt
  import axis_pcie_pipe_pkt_pkg::*;
#(
  parameter int NUM_PIPELINES = 1,
  parameter int MODE = 0,
  parameter bit TREADY_RST_VAL = 1'b0,
  parameter int NUM_CH = 1,
  parameter int CH_DW = 256,
  parameter int CH_UW = 10,
  localparam int OCC_W = axis_pipe_occ_w(NUM_PIPELINES, MODE)
) (
  input  logic             clk,
  input  logic             rst_n,
  axis_pcie_pipe_pkt_if.slave  s,
  axis_pcie_pipe_pkt_if.master m,
  input  logic             hold_req,
  output logic             hold_ack,
  output logic [OCC_W-1:0] occupancy,
  output logic [OCC_W-1:0] pkt_cnt
);
  localparam t_axis_pipe_mode PMODE = t_axis_pipe_mode'(MODE[1:0]);
  localparam int MAXOCC = NUM_PIPELINES * axis_pipe_depth(MODE);
  logic in_pkt, blk, chain_ready, s_acc;
  // a packet in flight always completes; only a new SOP is held off
  assign blk = hold_req & ~in_pkt;
  assign s.tready = !rst_n ? TREADY_RST_VAL : chain_ready & ~blk;
  assign s_acc = rst_n & s.tvalid & s.tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_pkt <= 1'b0;
    else if (s_acc) in_pkt <= ~s.tlast;
  if (NUM_PIPELINES < 1) begin : g_bad
    $error("axis_pcie_pipe_pkt: NUM_PIPELINES must be >= 1");
  end
  if (PMODE == BYPASS) begin : g_byp
    assign chain_ready = m.tready;
    assign m.tvalid = rst_n & s.tvalid & ~blk;
    assign m.tdata = s.tdata;
    assign m.tuser = s.tuser;
    assign m.tlast = s.tlast;
    assign occupancy = '0;
    assign pkt_cnt = '0;
    assign hold_ack = rst_n & blk;
  end else begin : g_pipe
    localparam int W = NUM_CH * (CH_DW + CH_UW) + 1;
    logic v [NUM_PIPELINES+1];
    logic r [NUM_PIPELINES+1];
    logic [W-1:0] d [NUM_PIPELINES+1];
    logic [OCC_W-1:0] occ_q, pkt_q;
    logic ack_q, m_acc;
    assign v[0] = s.tvalid & ~blk;
    assign d[0] = {s.tuser, s.tlast, s.tdata};
    assign chain_ready = r[0];
    for (genvar i = 0; i < NUM_PIPELINES; i++) begin : g_st
      axis_pcie_pipe_pkt_stage #(.W(W), .USE_SKID(PMODE == SKID)) u_st (
        .clk,
        .rst_n,
        .in_valid(v[i]),
        .in_ready(r[i]),
        .in_data(d[i]),
        .out_valid(v[i+1]),
        .out_ready(r[i+1]),
        .out_data(d[i+1])
      );
    end
    assign r[NUM_PIPELINES] = m.tready;
    assign m.tvalid = v[NUM_PIPELINES];
    assign {m.tuser, m.tlast, m.tdata} = d[NUM_PIPELINES];
    assign m_acc = m.tvalid & m.tready;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        occ_q <= '0;
        pkt_q <= '0;
        ack_q <= 1'b0;
      end else begin
        occ_q <= occ_q + OCC_W'(s_acc) - OCC_W'(m_acc);
        pkt_q <= pkt_q + OCC_W'(s_acc & s.tlast) - OCC_W'(m_acc & m.tlast);
        ack_q <= blk & (occ_q == '0);
      end
    assign occupancy = occ_q;
    assign pkt_cnt = pkt_q;
    assign hold_ack = ack_q;
  end
  a_no_withdraw: assert property (@(posedge clk) disable iff (!rst_n) s.tvalid && !s.tready |=> s.tvalid);
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) int'(occupancy) <= MAXOCC);
endmodule

// File: tb/tb_axis_pcie_pipe_pkt.sv
// tb_axis_pcie_pipe_pkt: randomized and directed checks of the pipeline against a queue-based model
module tb_axis_pcie_pipe_pkt;
  localparam int N = 2, NCH = 2, CDW = 256, CUW = 10, DW = NCH * CDW, UW = NCH * CUW;
  typedef logic [575:0] wv_t;
  typedef struct packed {logic l; logic [UW-1:0] u; logic [DW-1:0] d;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0, hold_req = 1'b0, hold_ack;
  logic [2:0] occupancy, pkt_cnt;
  logic b_hold = 1'b0, b_ack;
  logic [0:0] b_occ, b_pkt;
  axis_pcie_pipe_pkt_if #(.DW(DW), .UW(UW)) a_s(), a_m();
  axis_pcie_pipe_pkt_if #(.DW(16), .UW(4)) b_s(), b_m();
  axis_pcie_pipe_pkt #(.NUM_PIPELINES(N), .MODE(0), .TREADY_RST_VAL(1'b1), .NUM_CH(NCH), .CH_DW(CDW), .CH_UW(CUW)) dut (
    .clk, .rst_n, .s(a_s), .m(a_m), .hold_req, .hold_ack, .occupancy, .pkt_cnt);
  axis_pcie_pipe_pkt #(.NUM_PIPELINES(1), .MODE(2), .NUM_CH(1), .CH_DW(16), .CH_UW(4)) dut_b (
    .clk, .rst_n, .s(b_s), .m(b_m), .hold_req(b_hold), .hold_ack(b_ack), .occupancy(b_occ), .pkt_cnt(b_pkt));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference model: beats held = queue contents, packets held = tlast beats in the queue
  beat_t q[$];
  beat_t stall_b;
  bit inpk, ack_exp, stall, s_fire, m_fire;
  int acc_in_pkt, m_cnt, s_cnt;
  function automatic int n_last();
    int n = 0;
    foreach (q[i]) n += int'(q[i].l);
    return n;
  endfunction
  always @(negedge clk) begin
    beat_t sb, mb;
    sb = {a_s.tlast, a_s.tuser, a_s.tdata};
    mb = {a_m.tlast, a_m.tuser, a_m.tdata};
    s_fire = rst_n && a_s.tvalid && a_s.tready;
    m_fire = rst_n && a_m.tvalid && a_m.tready;
    if (!rst_n) begin
      q.delete();
      inpk = 0;
      ack_exp = 0;
      stall = 0;
      acc_in_pkt = 0;
    end else begin
      chk("occupancy", wv_t'(occupancy), wv_t'(q.size()));
      chk("pkt_cnt", wv_t'(pkt_cnt), wv_t'(n_last()));
      chk("hold_ack", wv_t'(hold_ack), wv_t'(ack_exp));
      if (hold_req && !inpk) chk("hold_gate", wv_t'(a_s.tready), wv_t'(0));
      if (stall) chk("m_stable", wv_t'({a_m.tvalid, mb}), wv_t'({1'b1, stall_b}));
      ack_exp = hold_req && !inpk && q.size() == 0;
      stall = a_m.tvalid && !a_m.tready;
      stall_b = mb;
      if (m_fire) begin
        m_cnt++;
        if (q.size() != 0) chk("payload", wv_t'(mb), wv_t'(q.pop_front()));
        else chk("m_underflow", wv_t'(m_fire), wv_t'(0));
      end
      if (s_fire) begin
        q.push_back(sb);
        inpk = !a_s.tlast;
        acc_in_pkt = a_s.tlast ? 0 : acc_in_pkt + 1;
        s_cnt++;
      end
    end
  end
  int left = 0, force_len = 0;
  task automatic new_beat();
    if (left == 0) left = force_len != 0 ? force_len : int'($urandom_range(5, 1));
    for (int i = 0; i < DW / 32; i++) a_s.tdata[i*32 +: 32] = $urandom;
    a_s.tuser = UW'($urandom);
    a_s.tlast = left == 1;
    left--;
    a_s.tvalid = 1'b1;
  endtask
  // a presented beat is only replaced once it has been accepted
  task automatic step(input int pv, input int pr);
    @(posedge clk);
    #1;
    if (s_fire || !a_s.tvalid) begin
      if (int'($urandom_range(99)) < pv) new_beat();
      else a_s.tvalid = 1'b0;
    end
    a_m.tready = int'($urandom_range(99)) < pr;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (left != 0 || a_s.tvalid); i++) step(left != 0 ? 100 : 0, 100);
    repeat (8) step(0, 100);
    chk("drain_empty", wv_t'({a_s.tvalid, occupancy}), wv_t'(0));
  endtask
  int ts, tm, tl, peak, pk, n0, m0, target;
  logic blk;
  bit binp;
  initial begin
    {a_s.tvalid, a_s.tlast, a_s.tdata, a_s.tuser, a_m.tready} = '0;
    {b_s.tvalid, b_s.tlast, b_s.tdata, b_s.tuser, b_m.tready} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", wv_t'(a_s.tready), wv_t'(1));
    chk("rst_m_tvalid", wv_t'(a_m.tvalid), wv_t'(0));
    chk("rst_counters", wv_t'({hold_ack, occupancy, pkt_cnt}), wv_t'(0));
    rst_n = 1'b1;
    force_len = 4;
    ts = -1; tm = -1; tl = -1; peak = 0; pk = 0; m0 = m_cnt;
    for (int t = 0; t < 20; t++) begin
      step(t == 0 || left != 0 ? 100 : 0, 100);
      if (s_fire && ts < 0) ts = t;
      if (m_fire && tm < 0) tm = t;
      if (m_fire) tl = t;
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (int'(pkt_cnt) > pk) pk = int'(pkt_cnt);
    end
    chk("latency", wv_t'(tm - ts), wv_t'(N));
    chk("lat_beats_out", wv_t'(m_cnt - m0), wv_t'(4));
    chk("lat_back_to_back", wv_t'(tl - tm), wv_t'(3));
    chk("lat_occ_peak", wv_t'(peak), wv_t'(N));
    chk("lat_pkt_peak", wv_t'(pk), wv_t'(1));
    force_len = 0;
    drain();
    for (int i = 0; i < 60; i++) begin
      if (i == 10) m0 = m_cnt;
      step(100, 100);
    end
    chk("throughput", wv_t'(m_cnt - m0), wv_t'(50));
    drain();
    n0 = s_cnt;
    repeat (10) step(100, 0);
    chk("bp_accepted", wv_t'(s_cnt - n0), wv_t'(4));
    chk("bp_occ", wv_t'(occupancy), wv_t'(4));
    chk("bp_s_tready", wv_t'(a_s.tready), wv_t'(0));
    a_m.tready = 1'b1;
    m0 = m_cnt;
    repeat (4) step(100, 100);
    chk("bp_release", wv_t'(m_cnt - m0), wv_t'(4));
    drain();
    force_len = 5;
    for (int i = 0; i < 50 && acc_in_pkt != 2; i++) step(100, 100);
    hold_req = 1'b1;
    n0 = s_cnt;
    repeat (12) step(100, 100);
    chk("hold_mid_accepted", wv_t'(s_cnt - n0), wv_t'(3));
    chk("hold_mid_sop_stall", wv_t'(a_s.tready), wv_t'(0));
    chk("hold_mid_ack", wv_t'(hold_ack), wv_t'(1));
    hold_req = 1'b0;
    #2;
    chk("hold_release_sop", wv_t'({a_s.tvalid, a_s.tready}), wv_t'(3));
    drain();
    force_len = 3;
    for (int i = 0; i < 50 && acc_in_pkt != 2; i++) step(100, 100);
    hold_req = 1'b1;
    n0 = s_cnt;
    repeat (8) step(100, 100);
    chk("hold_tlast_accepted", wv_t'(s_cnt - n0), wv_t'(1));
    chk("hold_tlast_ack", wv_t'(hold_ack), wv_t'(1));
    hold_req = 1'b0;
    drain();
    force_len = 5;
    for (int i = 0; i < 20 && q.size() != 3; i++) step(100, 0);
    rst_n = 1'b0;
    a_s.tvalid = 1'b0;
    left = 0;
    #1;
    chk("rst_mid_m_tvalid", wv_t'(a_m.tvalid), wv_t'(0));
    chk("rst_mid_counters", wv_t'({occupancy, pkt_cnt}), wv_t'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_req = 1'b1;
    repeat (2) step(0, 100);
    chk("rst_mid_inpkt_clear", wv_t'(hold_ack), wv_t'(1));
    hold_req = 1'b0;
    force_len = 2;
    n0 = s_cnt;
    repeat (3) step(100, 100);
    chk("rst_mid_new_pkt", wv_t'(s_cnt - n0), wv_t'(2));
    force_len = 0;
    target = m_cnt + 10000;
    for (int i = 0; i < 60000 && m_cnt < target; i++) begin
      step(50, 50);
      if (hold_req ? $urandom_range(9) == 0 : $urandom_range(99) == 0) hold_req = !hold_req;
    end
    chk("stress_done", wv_t'(m_cnt >= target), wv_t'(1));
    hold_req = 1'b0;
    drain();
    binp = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!(b_s.tvalid && !b_s.tready)) begin
        b_s.tvalid = 1'($urandom_range(1));
        b_s.tdata = 16'($urandom);
        b_s.tuser = 4'($urandom);
        b_s.tlast = 1'($urandom_range(1));
      end
      b_m.tready = 1'($urandom_range(1));
      b_hold = $urandom_range(2) == 0;
      #1;
      blk = b_hold && !binp;
      chk("byp_payload", wv_t'({b_m.tlast, b_m.tuser, b_m.tdata}), wv_t'({b_s.tlast, b_s.tuser, b_s.tdata}));
      chk("byp_m_tvalid", wv_t'(b_m.tvalid), wv_t'(b_s.tvalid && !blk));
      chk("byp_s_tready", wv_t'(b_s.tready), wv_t'(b_m.tready && !blk));
      chk("byp_hold_ack", wv_t'(b_ack), wv_t'(blk));
      chk("byp_counters", wv_t'({b_occ, b_pkt}), wv_t'(0));
      if (b_s.tvalid && b_m.tready && !blk) binp = !b_s.tlast;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
